// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic WR_READ   = 1'b1;
    localparam logic WR_WRITE  = 1'b0;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re_i,
    input  logic          rd_zero_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, WAIT_CYCLES wait states, stall to the LSU.
// Optional out-of-range detection enabled by defining DMEM_BOUNDS_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for cs low; accepts and latches the request
// BUSY  | counting down wait states with the latched request
// RESP  | one-cycle response: rvalid (read) or wack (write), stall released
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        rvalid,
    output logic        wack,
    output logic        stall,
    output logic        err
);

    localparam int AW = idx_width(DEPTH);

    state_e        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic          wr_q;
    logic [3:0]    mask_q;
    logic [AW-1:0] idx_q;
    logic          oob_q;
    logic [31:0]   wdata_q;
    logic          rvalid_q, wack_q, err_q;

    logic [AW-1:0] req_idx;
    logic          req_oob;
    logic          unused_addr;

    assign req_idx = addr[AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oob     = |addr[31:AW+2];
    assign unused_addr = ^addr[1:0];
`else
    assign req_oob     = 1'b0;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

    logic          latch_en, access;
    logic          acc_wr, acc_oob;
    logic [3:0]    acc_mask;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        latch_en = 1'b0;
        access   = 1'b0;
        acc_wr   = wr_q;
        acc_oob  = oob_q;
        acc_mask = mask_q;
        acc_idx  = idx_q;
        acc_data = wdata_q;
        case (state_q)
            IDLE: begin
                if (cs == CS_ACTIVE) begin
                    latch_en = 1'b1;
                    count_d  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access straight from the live request.
                        state_d  = RESP;
                        access   = 1'b1;
                        acc_wr   = wr;
                        acc_oob  = req_oob;
                        acc_mask = mask;
                        acc_idx  = req_idx;
                        acc_data = data_wr;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_q     <= WR_READ;
            mask_q   <= '0;
            idx_q    <= '0;
            oob_q    <= 1'b0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            if (latch_en) begin
                wr_q    <= wr;
                mask_q  <= mask;
                idx_q   <= req_idx;
                oob_q   <= req_oob;
                wdata_q <= data_wr;
            end
            rvalid_q <= access && (acc_wr == WR_READ);
            wack_q   <= access && (acc_wr == WR_WRITE);
            err_q    <= access && acc_oob;
        end
    end

    logic       arr_re;
    logic [3:0] arr_we;

    assign arr_re = access && (acc_wr == WR_READ);
    assign arr_we = (access && (acc_wr == WR_WRITE) && !acc_oob) ? acc_mask : 4'b0000;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_i      (arr_re),
        .rd_zero_i (acc_oob),
        .we_i      (arr_we),
        .idx_i     (acc_idx),
        .wdata_i   (acc_data),
        .rdata_o   (data_rd)
    );

    assign rvalid = rvalid_q;
    assign wack   = wack_q;
    assign err    = err_q;
    assign stall  = (cs == CS_ACTIVE) && (state_q != RESP);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the load/store unit's memory interface, owning the data RAM.
- Accepts one request at a time: active-low chip select, read/write select, byte mask, word address and write data.
- Commits stores per byte lane and returns full 32-bit load words. The LSU does all lane extraction and sign extension.
- Inserts a configurable number of wait states and signals them to the pipeline through a stall output.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; power of two.
WAIT_CYCLES, 0, extra access cycles between request acceptance and response; 0 to 15.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cs  input  1  chip select, active low; 0 means a request is present.
wr  input  1  1 means read (load), 0 means write (store).
mask  input  4  byte-lane write enables; bit i selects bits [8i+7:8i].
addr  input  32  byte address; bits [1:0] are ignored, word index is addr[log2(DEPTH)+1:2].
data_wr  input  32  store data, already lane-aligned by the LSU.
data_rd  output  32  registered read word.
rvalid  output  1  1 for exactly one cycle when data_rd holds the response to a read.
wack  output  1  1 for exactly one cycle when a write has been committed.
stall  output  1  holds the initiator while a request is outstanding.
err  output  1  out-of-range flag; see Optional Feature.

Behaviour:
- Reset: clk and rst_n as stated above; asynchronous, active low. State goes to IDLE; count, data_rd, rvalid, wack and err go to 0. Array contents are not reset.
- Reset mid-operation: the pending request is discarded. A write not yet committed is never committed.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if cs==0 at a rising edge, latch wr, mask, addr and data_wr, and load count=WAIT_CYCLES.
  - Next state is RESP if WAIT_CYCLES==0, otherwise BUSY.
- BUSY: count decrements each edge. When count==1, next state is RESP.
- Array access happens on the edge that enters RESP:
  - Write: lanes with mask bit set take data_wr lanes; other lanes are unchanged.
  - Read: data_rd <= array[index]; mask is ignored.
- RESP: lasts one cycle. rvalid=1 for a read, wack=1 for a write. Next state is always IDLE.
- data_rd holds its value until the next read completes.
- stall = (cs==0) && (state != RESP). This is combinational and has no registered path.
- Latency: an access takes WAIT_CYCLES+1 stalled cycles. The response is visible in the cycle stall drops.
- Back-to-back requests: a request held with cs==0 during RESP is not re-accepted. The initiator must deassert cs or change to the next request; a new acceptance happens in the following IDLE cycle.
- Request inputs that change while BUSY are ignored; the latched values are used.
- cs deasserted mid-BUSY: the transaction still completes, a write is still committed, and rvalid/wack still pulse.
- mask==0 on a write: no lane changes, but wack still pulses.
- Read and write never overlap, because only one transaction is outstanding.

Optional Feature:
Macro DMEM_BOUNDS_CHECK_EN.
- Defined: the address is out of range if addr[31:log2(DEPTH)+2] is nonzero.
  - Out-of-range write is suppressed; out-of-range read returns 0.
  - err=1 during that RESP cycle only.
  - rvalid/wack pulse normally.
- Undefined: upper address bits are ignored, so the address wraps modulo DEPTH words, and err is tied to 0.

Decomposition:
Package dmem_pkg holds:
- state enum {IDLE, BUSY, RESP};
- constants CS_ACTIVE=1'b0, WR_READ=1'b1, WR_WRITE=1'b0;
- localparam-style function for the index width (clog2).

Sub-module dmem_array:
- single-port word RAM with a 4-bit byte write enable and registered read;
- instantiated once; the FSM stays in dmem_responder.

Test Plan:
1. WAIT_CYCLES=0: write addr=0x10, data=0xDEADBEEF, mask=1111, then read 0x10 -> stall high for 1 cycle each, wack pulse, then rvalid=1 with data_rd=0xDEADBEEF.
2. Byte store: preload 0x11223344, then write addr=0x10, data=0x0000AB00, mask=0010, then read -> data_rd=0x1122AB44.
3. WAIT_CYCLES=3: read request -> stall high 4 cycles, rvalid on 5th cycle, inputs toggled during BUSY have no effect.
4. rst_n asserted in BUSY on a write to 0x20 (previously 0x0) -> outputs 0 immediately, later read of 0x20 returns 0x00000000.
5. DMEM_BOUNDS_CHECK_EN with DEPTH=1024: write addr=0x1000 -> err=1 one cycle, wack=1, and address 0x0 is unchanged. Without the macro, the same write lands at word 0.
6. Write with mask=0000 -> wack pulses, memory unchanged. Read addr=0x13 -> same word as 0x10.
